branch_resolve: RTL
===================

// Module: branch_resolve
// PURPOSE
//  Branch-resolution stage driven by the branch comparator's BrEq/BrLT flags in EX.
//  Drives BrUn to the comparator from funct3 and evaluates the condition of the branch or jump in EX.
//  Registers a PC redirect and runs a flush window that squashes the wrong-path instructions in the IF/ID stages.
// PARAMETERS
//  XLEN          32  datapath / PC width
//  FLUSH_CYCLES  2   cycles flush_o stays high after a redirect (range 1..7)
//  CNT_W         32  width of the performance counters (only with BR_PERF_CNT_EN)
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     synchronous reset, active-low
//  valid_i      in   1     control-flow instruction present in EX
//  is_branch_i  in   1     conditional branch (B-type)
//  is_jump_i    in   1     JAL/JALR, unconditionally taken
//  funct3_i     in   3     branch funct3
//  stall_i      in   1     pipeline stall; freezes the stage
//  BrEq         in   1     equal flag from the comparator
//  BrLT         in   1     less-than flag from the comparator
//  target_i     in   XLEN  computed branch/jump target
//  BrUn         out  1     unsigned-compare select to the comparator (combinational)
//  PCSel        out  1     redirect PC to redirect_pc_o (registered)
//  redirect_pc_o out XLEN  registered target
//  flush_o      out  1     squash IF/ID
//  misalign_o   out  1     one-cycle pulse: taken target with target_i[1:0]!=0
//  illegal_o    out  1     one-cycle pulse: is_branch_i with funct3 010/011
// BEHAVIOUR
//  Reset: all outputs 0, except BrUn, which follows funct3_i even in reset; state=IDLE; counters 0.
//  BrUn = funct3_i[1]: BLTU/BGEU compare unsigned, all others signed.
//  Accept = valid_i & ~stall_i & state==IDLE.
//  Taken decision (combinational):
//   - 000 BEQ: BrEq
//   - 001 BNE: ~BrEq
//   - 100/110 BLT/BLTU: BrLT
//   - 101/111 BGE/BGEU: ~BrLT
//   - 010/011: not taken; illegal_o pulses.
//   - is_jump_i forces taken and ignores funct3.
//   - is_branch_i and is_jump_i both set: the jump wins.
//  Misaligned target: taken & target_i[1:0]!=0 -> misalign_o pulses next cycle, no redirect.
//  FSM IDLE/REDIRECT/SQUASH:
//   - IDLE: accept & taken & aligned -> REDIRECT. On the next edge PCSel=1, redirect_pc_o=target_i, flush_o=1.
//   - REDIRECT (1 cycle, PCSel=1): PCSel drops on exit. Goes to SQUASH if FLUSH_CYCLES>1, else to IDLE.
//   - SQUASH: flush_o held; down-counter from FLUSH_CYCLES-1; IDLE when it reaches 0.
//  Latency: decision to PCSel/flush is 1 cycle. Not-taken produces no output activity.
//  valid_i during REDIRECT/SQUASH belongs to a wrong-path instruction: it is ignored and not counted.
//  stall_i freezes the FSM and counter, and no new accept occurs. PCSel and flush_o hold their values during the stall.
//  Reset mid-flush: returns to IDLE with all outputs 0 on the next edge.
// CONFIGURATION
//  BR_PERF_CNT_EN defined:
//   - Adds outputs br_cnt_o, taken_cnt_o (CNT_W each).
//   - br_cnt_o increments on every accepted is_branch_i; taken_cnt_o increments on every accepted taken branch or jump.
//   - Both wrap modulo 2^CNT_W.
//  BR_PERF_CNT_EN undefined: these ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  Package riscv_br_pkg: funct3 constants (F3_BEQ..F3_BGEU) and the state enum br_state_t {IDLE, REDIRECT, SQUASH}.
//  Sub-module br_decide (combinational): funct3/BrEq/BrLT/is_jump -> taken, illegal.
//  The top level holds the FSM, flush counter, output registers and optional counters.
// TESTING
//  1. BEQ, BrEq=1, target=0x100 -> next cycle PCSel=1, redirect_pc_o=0x100, flush_o high for exactly 2 cycles.
//  2. BGEU: funct3=111 -> BrUn=1. BrLT=1 -> not taken; no PCSel or flush at any later cycle.
//  3. JAL, target=0x102 -> misalign_o pulses once; PCSel stays 0.
//  4. funct3=010 branch -> illegal_o one pulse, no redirect. A valid_i during SQUASH -> ignored and not counted.
//  5. stall_i high for 3 cycles during SQUASH -> flush_o extends by 3 cycles. rst_n=0 mid-flush -> all outputs 0 on the next edge.
//  6. (BR_PERF_CNT_EN, CNT_W=4) 17 taken BNEs -> br_cnt_o=1, taken_cnt_o=1 (wrap).

Source files
------------

// File: rtl/riscv_br_pkg.sv
// riscv_br_pkg: branch funct3 encodings and branch-resolve FSM states
package riscv_br_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} br_state_t;
endpackage

// File: rtl/br_decide.sv
// br_decide: combinational taken/illegal decision from funct3 and comparator flags
module br_decide
    import riscv_br_pkg::*;
(
    input  logic       isBranch,
    input  logic       isJump,
    input  logic [2:0] funct3,
    input  logic       brEq,
    input  logic       brLt,
    output logic       taken,
    output logic       illegal
);
    logic cond;
    // Jumps are always taken and override any branch decode; 010/011 never take
    always_comb begin
        cond = (funct3 == F3_BEQ) ? brEq :
               (funct3 == F3_BNE) ? ~brEq :
               (funct3 == F3_BLT || funct3 == F3_BLTU) ? brLt :
               (funct3 == F3_BGE || funct3 == F3_BGEU) ? ~brLt : 1'b0;
        taken = isJump | (isBranch & cond);
        illegal = isBranch & ~isJump & (funct3[2:1] == 2'b01);
    end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution, PC redirect and IF/ID flush window (optional BR_PERF_CNT_EN counters)
module branch_resolve
    import riscv_br_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FLUSH_CYCLES = 2
`ifdef BR_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            is_branch_i,
    input  logic            is_jump_i,
    input  logic [2:0]      funct3_i,
    input  logic            stall_i,
    input  logic            BrEq,
    input  logic            BrLT,
    input  logic [XLEN-1:0] target_i,
    output logic            BrUn,
    output logic            PCSel,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic            illegal_o
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
`endif
);
    br_state_t state, nextState;
    logic [2:0] cnt, nextCnt;
    logic taken, illegal, accept, aligned, go;

    br_decide uDecide (
        .isBranch(is_branch_i),
        .isJump  (is_jump_i),
        .funct3  (funct3_i),
        .brEq    (BrEq),
        .brLt    (BrLT),
        .taken   (taken),
        .illegal (illegal)
    );

    // Accept only in IDLE so wrong-path instructions during a flush are dropped
    always_comb begin
        BrUn = funct3_i[1];
        accept = valid_i & ~stall_i & (state == IDLE);
        aligned = (target_i[1:0] == 2'b00);
        go = accept & taken & aligned;
    end

    // Next-state logic; a stall freezes both the state and the flush counter
    always_comb begin
        nextState = state;
        nextCnt = cnt;
        if (!stall_i) begin
            case (state)
                IDLE: nextState = go ? REDIRECT : IDLE;
                REDIRECT: begin
                    nextState = (FLUSH_CYCLES > 1) ? SQUASH : IDLE;
                    nextCnt = 3'(FLUSH_CYCLES - 1);
                end
                SQUASH: begin
                    nextCnt = cnt - 3'd1;
                    nextState = (cnt == 3'd1) ? IDLE : SQUASH;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs; PCSel/flush derive from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 3'd0;
            PCSel <= 1'b0;
            flush_o <= 1'b0;
            redirect_pc_o <= '0;
            misalign_o <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            PCSel <= (nextState == REDIRECT);
            flush_o <= (nextState != IDLE);
            if (go) redirect_pc_o <= target_i;
            misalign_o <= accept & taken & ~aligned;
            illegal_o <= accept & illegal;
        end
    end

`ifdef BR_PERF_CNT_EN
    // Performance counters over accepted instructions, wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_o <= '0;
            taken_cnt_o <= '0;
        end else begin
            if (accept & is_branch_i) br_cnt_o <= br_cnt_o + 1'b1;
            if (accept & taken) taken_cnt_o <= taken_cnt_o + 1'b1;
        end
    end
`endif
endmodule
